// File: rtl/fetch_pc_btb.sv
// Fetch PC generator with a direct-mapped branch target buffer.
// Each BTB entry holds valid, tag, target and a 2-bit saturating counter.
// Lookup is combinational on the current pc. Updates from the EX stage are
// written on the clock edge.
//
// Ports:
//   clk, reset       rising-edge clock; synchronous active-high reset
//   stall            holds pc (a mispredict redirect still wins)
//   ex_*             resolved control-transfer information from EX
//   pc               current fetch PC (registered)
//   pred_taken       BTB hit with counter MSB set (combinational)
//   pred_target      BTB target on a hit, else 0 (combinational)
//   btb_miss         misprediction resolved this cycle (combinational)
//   mispredict_cnt   saturating count of mispredicts (registered)
module fetch_pc_btb #(
  parameter int unsigned ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic        ex_taken,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        btb_miss,
  output logic [15:0] mispredict_cnt
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;

  logic [IDX-1:0]   f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit;
  logic             mispredict;
  logic [1:0]       e_ctr, e_ctr_d;
  logic [31:0]      pc_plus4;

  // Byte offset bits of ex_pc never reach the table.
  logic unused_ex_pc;
  assign unused_ex_pc = ^ex_pc[1:0];

  // Fetch-side lookup.
  assign f_idx = pc_q[IDX+1:2];
  assign f_tag = pc_q[31:IDX+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign pred_taken  = !reset && f_hit && ctr_q[f_idx][1];
  assign pred_target = (!reset && f_hit) ? target_q[f_idx] : 32'h0;

  // Resolution-side checks: wrong direction, or taken to the wrong place.
  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));
  assign btb_miss   = !reset && mispredict;

  assign e_idx = ex_pc[IDX+1:2];
  assign e_tag = ex_pc[31:IDX+2];
  assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
  assign e_ctr = ctr_q[e_idx];

  assign pc_plus4 = 32'(pc_q + 32'd4);

  // Counter update for a hitting entry.
  always_comb begin
    e_ctr_d = e_ctr;
    if (ex_taken && (e_ctr != 2'd3)) begin
      e_ctr_d = 2'(e_ctr + 2'd1);
    end else if (!ex_taken && (e_ctr != 2'd0)) begin
      e_ctr_d = 2'(e_ctr - 2'd1);
    end
  end

  // Next-PC selection; mispredict beats stall, reset handled in the register.
  always_comb begin
    pc_d = pc_plus4;
    if (mispredict) begin
      pc_d = ex_taken ? ex_target : 32'(ex_pc + 32'd4);
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mispredict && (cnt_q != 16'hFFFF)) begin
      cnt_d = 16'(cnt_q + 16'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= 16'h0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  // Table write: clear on reset, otherwise train on resolved branches.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ex_valid) begin
      if (e_hit) begin
        ctr_q[e_idx] <= e_ctr_d;
        if (ex_taken) begin
          target_q[e_idx] <= ex_target;
        end
      end else if (ex_taken) begin
        valid_q[e_idx]  <= 1'b1;
        tag_q[e_idx]    <= e_tag;
        target_q[e_idx] <= ex_target;
        ctr_q[e_idx]    <= 2'b10;
      end
    end
  end

  assign pc             = pc_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_btb.sv
// Table-driven bench for fetch_pc_btb with an expected-value queue.
module tb_fetch_pc_btb;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        btb_miss;
  logic [15:0] mispredict_cnt;

  fetch_pc_btb #(.ENTRIES(16), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .ex_valid       (ex_valid),
    .ex_taken       (ex_taken),
    .ex_pc          (ex_pc),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc             (pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .btb_miss       (btb_miss),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        exv;
    logic        ext;
    logic [31:0] expc;
    logic [31:0] extgt;
    logic        expt;
    logic [31:0] exptgt;
    bit          chk_state;
    logic [31:0] e_pc;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_miss;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_vec = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic rst, logic stl, logic exv, logic ext,
                              logic [31:0] expc, logic [31:0] extgt,
                              logic expt, logic [31:0] exptgt,
                              logic [31:0] epc, logic ept, logic [31:0] eptgt,
                              logic emiss, logic [15:0] ecnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.exv = exv; v.ext = ext;
    v.expc = expc; v.extgt = extgt; v.expt = expt; v.exptgt = exptgt;
    v.chk_state = 1'b1;
    v.e_pc = epc; v.e_pt = ept; v.e_ptgt = eptgt; v.e_miss = emiss; v.e_cnt = ecnt;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] epc, logic ept, logic [31:0] eptgt,
                                logic [15:0] ecnt);
    return mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
              epc, ept, eptgt, 1'b0, ecnt);
  endfunction

  task automatic check32(string name, int idx, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, req);
    end
  endtask

  // Drive one cycle's inputs, queue its expectation, then compare mid-cycle.
  task automatic apply(vec_t v);
    vec_t e;
    @(negedge clk);
    reset          = v.rst;
    stall          = v.stl;
    ex_valid       = v.exv;
    ex_taken       = v.ext;
    ex_pc          = v.expc;
    ex_target      = v.extgt;
    ex_pred_taken  = v.expt;
    ex_pred_target = v.exptgt;
    exp_q.push_back(v);
    #1;
    e = exp_q.pop_front();
    check32("btb_miss",    n_vec, 32'(btb_miss),   32'(e.e_miss));
    check32("pred_taken",  n_vec, 32'(pred_taken), 32'(e.e_pt));
    check32("pred_target", n_vec, pred_target,     e.e_ptgt);
    if (e.chk_state) begin
      check32("pc",             n_vec, pc,                  e.e_pc);
      check32("mispredict_cnt", n_vec, 32'(mispredict_cnt), 32'(e.e_cnt));
    end
    n_vec++;
  endtask

  initial begin
    vec_t v0;
    reset = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_taken = 1'b0;
    ex_pc = 32'h0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_target = 32'h0;

    // Reset held two cycles with a competing taken mispredict that must be ignored.
    v0 = mk(1, 0, 1, 1, 32'h0, 32'h100, 0, 32'h0, 32'h0, 0, 32'h0, 0, 16'd0);
    v0.chk_state = 1'b0;
    vecs.push_back(v0);
    vecs.push_back(mk(1, 0, 1, 1, 32'h0, 32'h100, 0, 32'h0, 32'h0, 0, 32'h0, 0, 16'd0));
    // Sequential fetch after release.
    vecs.push_back(idle(32'h0, 0, 32'h0, 16'd0));
    vecs.push_back(idle(32'h4, 0, 32'h0, 16'd0));
    vecs.push_back(idle(32'h8, 0, 32'h0, 16'd0));
    vecs.push_back(idle(32'hC, 0, 32'h0, 16'd0));
    // Cold taken branch at 0x10; same-cycle lookup at 0x10 still sees old (empty) entry.
    vecs.push_back(mk(0, 0, 1, 1, 32'h10, 32'h40, 0, 32'h0, 32'h10, 0, 32'h0, 1, 16'd0));
    vecs.push_back(idle(32'h40, 0, 32'h0, 16'd1));
    // Not-taken mispredict at 0xC redirects to 0x10.
    vecs.push_back(mk(0, 0, 1, 0, 32'hC, 32'h0, 1, 32'h10, 32'h44, 0, 32'h0, 1, 16'd1));
    // Warm prediction.
    vecs.push_back(idle(32'h10, 1, 32'h40, 16'd2));
    vecs.push_back(idle(32'h40, 0, 32'h0, 16'd2));
    // Four correctly-predicted not-taken updates drive the counter to 0.
    vecs.push_back(mk(0, 0, 1, 0, 32'h10, 32'h0, 0, 32'h0, 32'h44, 0, 32'h0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h10, 32'h0, 0, 32'h0, 32'h48, 0, 32'h0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h10, 32'h0, 0, 32'h0, 32'h4C, 0, 32'h0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'h10, 32'h0, 0, 32'h0, 32'h50, 0, 32'h0, 0, 16'd2));
    // One taken update, correctly predicted: counter 0 -> 1.
    vecs.push_back(mk(0, 0, 1, 1, 32'h10, 32'h40, 1, 32'h40, 32'h54, 0, 32'h0, 0, 16'd2));
    vecs.push_back(mk(0, 0, 1, 0, 32'hC, 32'h0, 1, 32'h0, 32'h58, 0, 32'h0, 1, 16'd2));
    // Hit but weakly not-taken: target visible, not predicted.
    vecs.push_back(idle(32'h10, 0, 32'h40, 16'd3));
    // Mispredict during stall wins.
    vecs.push_back(mk(0, 1, 1, 0, 32'h20, 32'h0, 1, 32'h99, 32'h14, 0, 32'h0, 1, 16'd3));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h24, 0, 32'h0, 0, 16'd4));
    vecs.push_back(idle(32'h24, 0, 32'h0, 16'd4));
    // Aliasing: 0x50 maps onto 0x10's entry and replaces it.
    vecs.push_back(mk(0, 0, 1, 1, 32'h10, 32'h40, 1, 32'h40, 32'h28, 0, 32'h0, 0, 16'd4));
    vecs.push_back(mk(0, 0, 1, 1, 32'h50, 32'h80, 0, 32'h0, 32'h2C, 0, 32'h0, 1, 16'd4));
    vecs.push_back(mk(0, 0, 1, 0, 32'hC, 32'h0, 1, 32'h0, 32'h80, 0, 32'h0, 1, 16'd5));
    vecs.push_back(idle(32'h10, 0, 32'h0, 16'd6));
    // Redirect to the top of the address space; pc+4 wraps to 0.
    vecs.push_back(mk(0, 0, 1, 1, 32'h200, 32'hFFFF_FFFC, 0, 32'h0, 32'h14, 0, 32'h0, 1, 16'd6));
    vecs.push_back(idle(32'hFFFF_FFFC, 0, 32'h0, 16'd7));
    vecs.push_back(idle(32'h0, 0, 32'h0, 16'd7));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
    end

    // Mid-run reset with stall and mispredict present: outputs quiet, state cleared.
    apply(mk(1, 1, 1, 1, 32'h50, 32'h300, 0, 32'h0, 32'h4, 0, 32'h0, 0, 16'd7));
    apply(idle(32'h0, 0, 32'h0, 16'd0));
    apply(mk(0, 0, 1, 0, 32'h4C, 32'h0, 1, 32'h0, 32'h4, 0, 32'h0, 1, 16'd0));
    // 0x50 was trained before reset; the cleared table must miss.
    apply(idle(32'h50, 0, 32'h0, 16'd1));
    // Plain stall holds pc.
    apply(mk(0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h54, 0, 32'h0, 0, 16'd1));
    apply(idle(32'h54, 0, 32'h0, 16'd1));
    apply(idle(32'h58, 0, 32'h0, 16'd1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_pc_btb.md
FETCH_PC_BTB -- requirements
Module: fetch_pc_btb

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16, giving the BTB entry count; power of two, 4..64.
REQ-002 SHALL provide parameter RESET_PC, default 32'h0000_0000, giving the PC loaded on reset.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  holds PC and suppresses prediction advance when high.
REQ-006 SHALL have port ex_valid  input  1  EX-stage resolved control-transfer update present.
REQ-007 SHALL have port ex_taken  input  1  actual outcome of the resolved branch.
REQ-008 SHALL have port ex_pc  input  32  PC of the resolved branch.
REQ-009 SHALL have port ex_target  input  32  actual taken target of the resolved branch.
REQ-010 SHALL have port ex_pred_taken  input  1  prediction carried down the pipe with the branch.
REQ-011 SHALL have port ex_pred_target  input  32  predicted target carried down the pipe.
REQ-012 SHALL have port pc  output  32  current fetch PC to instruction memory.
REQ-013 SHALL have port pred_taken  output  1  BTB predicts taken for current pc.
REQ-014 SHALL have port pred_target  output  32  BTB target for current pc; 0 when not hit.
REQ-015 SHALL have port btb_miss  output  1  misprediction detected this cycle; used with PCSrc to flush IF/ID.
REQ-016 SHALL have port mispredict_cnt  output  16  saturating misprediction counter.

Function
REQ-017 SHALL index the BTB with pc[IDX+1:2] and tag with pc[31:IDX+2], where IDX = log2(ENTRIES).
REQ-018 SHALL store per entry: valid, tag, 32-bit target, and a 2-bit saturating counter.
REQ-019 SHALL perform lookup combinationally on the current pc; hit = valid & tag match; pred_taken = hit & ctr[1].
REQ-020 SHALL compute mispredict = ex_valid & ((ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target)).
REQ-021 SHALL drive btb_miss = mispredict combinationally, in the same cycle as the EX update.
REQ-022 SHALL select next pc by priority: reset -> RESET_PC; mispredict -> (ex_taken ? ex_target : ex_pc+4); stall -> pc; pred_taken -> pred_target; else pc+4.
REQ-023 SHALL give mispredict priority over stall.
REQ-024 SHALL wrap pc+4 modulo 2^32 with no flag.
REQ-025 SHALL, on ex_valid with a tag hit at ex_pc's index, increment the counter on taken (saturating at 3), decrement it on not-taken (saturating at 0), and write ex_target when taken.
REQ-026 SHALL, on ex_valid with a tag miss and ex_taken, allocate or overwrite the entry: valid=1, tag, target=ex_target, ctr=2'b10.
REQ-027 SHALL NOT allocate on a tag miss with not-taken.
REQ-028 SHALL write the table on the clock edge only, so a same-cycle lookup of the entry being updated returns the old contents.
REQ-029 SHALL perform updates regardless of stall.
REQ-030 SHALL increment mispredict_cnt on each mispredict cycle and saturate at 16'hFFFF.

Reset
REQ-031 SHALL, on reset, set pc=RESET_PC, clear all valid bits, set all counters to 2'b01, and set mispredict_cnt=0, all in one cycle.
REQ-032 SHALL hold pred_taken=0, pred_target=0 and btb_miss=0 while reset is high.
REQ-033 SHALL let reset override a concurrent mispredict, stall or update; no table write occurs in that cycle.

Verification
REQ-034 SHALL cover reset: hold reset 2 cycles, then release with no ex_valid -> pc sequence 0, 4, 8, 12; pred_taken=0.
REQ-035 SHALL cover cold taken branch: ex_valid, ex_pc=0x10, ex_taken=1, ex_target=0x40, ex_pred_taken=0 -> btb_miss=1 that cycle; next pc=0x40; mispredict_cnt=1.
REQ-036 SHALL cover warm prediction: after REQ-035, fetch reaches pc=0x10 -> pred_taken=1, pred_target=0x40, next pc=0x40.
REQ-037 SHALL cover counter saturation: four not-taken updates at 0x10 -> ctr=0, pred_taken=0; one taken update -> ctr=1, still not predicted.
REQ-038 SHALL cover mispredict during stall: stall=1 with a not-taken mispredict at ex_pc=0x20 -> next pc=0x24, btb_miss=1.
REQ-039 SHALL cover aliasing: taken update at 0x10, then a taken update at 0x10+4*ENTRIES with target 0x80 -> entry replaced; pc=0x10 misses.
